pb_debounce_bank: RTL
=====================

// Module: pb_debounce_bank
// PURPOSE
//  Parametrised N-channel push-button conditioner.
//  Per channel: 2-FF synchroniser, optional input inversion, stability-count debounce,
//  one-cycle press/release strobes, and a one-shot long-press strobe.
//  Sits between raw board buttons/switches and control FSMs; one instance serves the whole button bank.
// PARAMETERS
//  NUM_CH      5            number of independent channels
//  ACTIVE_LOW  1            1: raw pin low = pressed (input inverted); 0: raw high = pressed
//  STABLE_CNT  65535        consecutive disagreeing cycles needed to accept a change; 1..2^24-1
//  LONG_CNT    100000000    cycles of debounced "pressed" before long_press fires; >=1
//  (derived) CNT_W = $clog2(STABLE_CNT+1), LONG_W = $clog2(LONG_CNT+1)
// PORTS
//  clk         in   1        system clock; all flops on posedge
//  rst_n       in   1        asynchronous, active-low reset
//  pb_raw      in   NUM_CH   raw asynchronous button pins, bit i = channel i
//  pb_state    out  NUM_CH   debounced level, 1 = pressed (after polarity fix)
//  pb_press    out  NUM_CH   1-cycle strobe when pb_state 0->1
//  pb_release  out  NUM_CH   1-cycle strobe when pb_state 1->0
//  pb_long     out  NUM_CH   1-cycle strobe after LONG_CNT cycles held pressed
//  pb_any      out  1        OR of pb_state
// BEHAVIOUR
//  Reset (rst_n=0, async): sync flops, counters, pb_state, all strobes, pb_any -> 0 immediately;
//   held while rst_n=0; first evaluation on first posedge after release. Mid-operation reset
//   discards partial counts; a held button is re-detected as a fresh press afterwards.
//  Input: in_i = ACTIVE_LOW ? ~pb_raw[i] : pb_raw[i]; sync0 <= in_i; sync1 <= sync0.
//  Debounce, per channel, each posedge:
//   - sync1 == pb_state: cnt <= 0 (any agreeing cycle cancels accumulation, no partial credit)
//   - else if cnt == STABLE_CNT-1: pb_state <= ~pb_state; cnt <= 0; strobe press or release
//   - else cnt <= cnt + 1
//  Latency: pb_raw settling before posedge 1 -> pb_state toggles on posedge STABLE_CNT+2;
//   strobes registered, high the same cycle pb_state first shows new value, exactly 1 cycle.
//  Long press: hold_cnt clears while pb_state==0; while 1, increments and saturates at LONG_CNT.
//   pb_long pulses once on the edge hold_cnt goes LONG_CNT-1 -> LONG_CNT, i.e. LONG_CNT cycles
//   after the pb_press cycle; no further pb_long until release and a new press.
//   Release before then: no pb_long. pb_long and pb_release never coincide on one channel.
//  Channels fully independent; simultaneous events on several channels all reported same cycle.
//  No counter wraps: cnt max STABLE_CNT-1, hold_cnt saturates.
//  pb_any = |pb_state (combinational from registered state).
// TESTING (bench params: NUM_CH=2, ACTIVE_LOW=1, STABLE_CNT=4, LONG_CNT=10)
//  1 Reset: rst_n=0 mid-cycle with pb_raw=2'b00 -> all outputs 0 at once, stay 0 while rst_n=0.
//  2 Clean press ch0: pb_raw[0] 1->0 before edge 1 -> pb_state[0]=1 and pb_press[0]=1 after
//    edge 6, pb_press[0]=0 after edge 7; pb_any=1.
//  3 Bounce ch1: pb_raw[1] low 3 cycles, high 1, low 3, high -> pb_state[1] never changes,
//    no strobes.
//  4 Long press ch0: hold 20 cycles past pb_press -> one pb_long[0] 10 cycles after pb_press,
//    none after; release -> pb_release[0] 6 cycles after pb_raw[0] returns high.
//  5 Short press ch0 held 5 cycles after pb_press -> press/release strobes, pb_long stays 0.
//  6 Both channels pressed same cycle, rst_n pulsed low 2 cycles after pb_state=2'b11 ->
//    outputs 0 at once; after rst_n=1, pb_press=2'b11 again STABLE_CNT+2 edges later.

Source files
------------

// File: rtl/pb_debounce_bank.sv
// Push-button conditioner for a bank of NUM_CH channels.
// Each channel has a 2-FF synchroniser, a stability-count debounce, press/release strobes and a one-shot long-press strobe.
module pb_debounce_bank #(
    parameter int NUM_CH     = 5,
    parameter int ACTIVE_LOW = 1,
    parameter int STABLE_CNT = 65535,
    parameter int LONG_CNT   = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pb_raw,
    output logic [NUM_CH-1:0] pb_state,
    output logic [NUM_CH-1:0] pb_press,
    output logic [NUM_CH-1:0] pb_release,
    output logic [NUM_CH-1:0] pb_long,
    output logic              pb_any
);

    localparam int CNT_W  = $clog2(STABLE_CNT + 1);
    localparam int LONG_W = $clog2(LONG_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic [NUM_CH-1:0] level_in;
    logic [NUM_CH-1:0] sync0;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] toggle;
    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [LONG_W-1:0] hold_cnt [NUM_CH];

    assign level_in = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;
    assign pb_any   = |pb_state;

    // A channel flips on the edge that would complete STABLE_CNT disagreeing samples.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            toggle[i] = (sync1[i] != pb_state[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0      <= '0;
            sync1      <= '0;
            pb_state   <= '0;
            pb_press   <= '0;
            pb_release <= '0;
            pb_long    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync0      <= level_in;
            sync1      <= sync0;
            pb_press   <= toggle & ~pb_state;
            pb_release <= toggle & pb_state;
            pb_state   <= pb_state ^ toggle;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((sync1[i] == pb_state[i]) || toggle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                if (!pb_state[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != LONG_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + LONG_W'(1);
                end

                // A release landing on the long-press edge wins, so the two strobes never coincide.
                pb_long[i] <= pb_state[i] && !toggle[i] && (hold_cnt[i] == LONG_LAST);
            end
        end
    end

endmodule
